// File: rtl/sram_req_ctrl_if.sv
// sram_req_ctrl_if: request/response handshake bundle
// between a pipeline stage and the SRAM requester.
interface sram_req_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48,
  parameter int MASK_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready front end for a 1-cycle
// masked single-port SRAM, with zero-fill and read FIFO.
module sram_req_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 48,
  parameter int MASK_W        = 8,
  parameter int RESP_DEPTH    = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_req_ctrl_if.slave    bus,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam state_t RST_STATE =
    (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
  localparam logic RST_DONE = (INIT_ON_RESET == 0);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW =
    (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);
  localparam logic [CW:0]   CAP  = (CW + 1)'(RESP_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;

  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

  logic init_drive;
  logic run;
  logic pop;
  logic push;
  logic accept;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Strobes are gated by reset_n so they drop the
  // moment reset asserts, not at the next edge.
  assign init_drive = reset_n && (state == S_INIT);
  assign run        = reset_n && (state == S_RUN);

  assign push = inflight;
  assign pop  = bus.resp_valid && bus.resp_ready;

  assign bus.resp_valid = (count != '0);
  assign bus.resp_rdata = fifo_mem[rd_ptr];

  // Credit: slots already used or promised, net of
  // this cycle's pop, must leave room for a new read.
  assign occ = {1'b0, count}
             + (CW + 1)'(inflight)
             - (CW + 1)'(pop);

  assign bus.req_ready =
    run && (bus.req_write || (occ < CAP));
  assign accept = bus.req_valid && bus.req_ready;

  // Mode FSM: zero-fill sweep, then steady run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RST_STATE;
      init_ptr  <= '0;
      init_done <= RST_DONE;
    end else begin
      unique case (state)
        S_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (&init_ptr) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          init_done <= 1'b1;
        end
        default: begin
          state <= RST_STATE;
        end
      endcase
    end
  end

  // Macro strobes: sweep writes in INIT, pass-through
  // of the accepted request in RUN, idle otherwise.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    unique case (1'b1)
      init_drive: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_ptr;
        sram_wmask = '1;
      end
      accept: begin
        sram_en    = 1'b1;
        sram_wmode = bus.req_write;
        sram_addr  = bus.req_addr;
        sram_wmask = bus.req_write ? bus.req_wmask : '0;
        sram_wdata = bus.req_wdata;
      end
      default: begin
        sram_en = 1'b0;
      end
    endcase
  end

  // Read tracking and FIFO bookkeeping; reset drops
  // any read whose data has not landed yet.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= accept && !bus.req_write;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset; count gates its use.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed bench with a behavioural
// masked 1-cycle SRAM hanging off the strobe outputs.
module tb_sram_req_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_done;
  logic        sram_en;
  logic        sram_wmode;
  logic [7:0]  sram_addr;
  logic [7:0]  sram_wmask;
  logic [47:0] sram_wdata;
  logic [47:0] sram_rdata = '0;

  logic [47:0] mem [256];

  int errors = 0;
  int checks = 0;

  sram_req_ctrl_if #(
    .ADDR_W(8), .DATA_W(48), .MASK_W(8)
  ) bus ();

  sram_req_ctrl #(
    .ADDR_W(8), .DATA_W(48), .MASK_W(8),
    .RESP_DEPTH(2), .INIT_ON_RESET(1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural macro: 6-bit mask segments, read data
  // registered one cycle after the enable.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < 8; s++) begin
          if (sram_wmask[s]) begin
            mem[sram_addr][s*6 +: 6] <= sram_wdata[s*6 +: 6];
          end
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic        w,
    input logic [7:0]  a,
    input logic [7:0]  m,
    input logic [47:0] d
  );
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
  endtask

  function automatic logic [47:0] pat(input int i);
    return 48'h5A00_C3A5_0000 ^ (48'(i + 1) * 48'h0102_0304_0507);
  endfunction

  task automatic check_idle_reset(input string tag);
    chk(tag, {init_done, bus.req_ready, bus.resp_valid,
              sram_en, sram_wmode, sram_addr,
              sram_wmask, sram_wdata},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
         8'h00, 48'h0});
  endtask

  // Expects to be entered just after reset release;
  // checks one sweep strobe per cycle.
  task automatic run_init(input int n);
    for (int k = 0; k < n; k++) begin
      chk("init_strobe",
          {init_done, bus.req_ready, sram_en, sram_wmode,
           sram_addr, sram_wmask, sram_wdata},
          {1'b0, 1'b0, 1'b1, 1'b1, 8'(k), 8'hFF, 48'h0});
      tick();
    end
  endtask

  logic [7:0]  s_addr [7];
  logic [47:0] s_exp  [7];

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d",
             errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 48'hDEAD_BEEF_0000 | 48'(i);
    end
    drive(0, 0, 8'h00, 8'h00, 48'h0);
    bus.resp_ready = 1'b0;

    // 1: reset values, then full zero-fill sweep
    repeat (2) tick();
    check_idle_reset("reset_outputs");
    reset_n = 1'b1;
    #1;
    run_init(256);
    chk("init_done_257", {init_done, sram_en, bus.req_ready},
        {1'b1, 1'b0, 1'b1});

    // 2: masked write merge, then read back
    drive(1, 1, 8'h12, 8'hFF, 48'hABCD_EF01_2345);
    #1;
    chk("wr_strobe",
        {bus.req_ready, sram_en, sram_wmode, sram_addr,
         sram_wmask, sram_wdata},
        {1'b1, 1'b1, 1'b1, 8'h12, 8'hFF, 48'hABCD_EF01_2345});
    tick();
    drive(1, 1, 8'h12, 8'h0F, 48'h0);
    #1;
    chk("wr_mask_strobe", {sram_en, sram_wmode, sram_wmask},
        {1'b1, 1'b1, 8'h0F});
    tick();
    drive(1, 0, 8'h12, 8'hFF, 48'h1111_1111_1111);
    #1;
    chk("rd_strobe",
        {bus.req_ready, sram_en, sram_wmode, sram_addr,
         sram_wmask, sram_wdata},
        {1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 48'h1111_1111_1111});
    tick();
    drive(0, 0, 8'h00, 8'h00, 48'h0);
    bus.resp_ready = 1'b1;
    #1;
    chk("rd_lat_edge1", {bus.resp_valid, sram_en},
        {1'b0, 1'b0});
    tick();
    chk("rd_valid", bus.resp_valid, 1'b1);
    chk("rd_merge_data", bus.resp_rdata, 48'hABCD_EF00_0000);
    tick();
    chk("rd_popped", bus.resp_valid, 1'b0);

    // preload 0x20..0x23 with distinct words
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'(32 + i), 8'hFF, pat(i));
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 48'h0);

    // 3 + 6: backpressure, then writes while full
    bus.resp_ready = 1'b0;
    drive(1, 0, 8'h20, 8'h00, 48'h0);
    #1;
    chk("bp_rd0_ready", bus.req_ready, 1'b1);
    tick();
    drive(1, 0, 8'h21, 8'h00, 48'h0);
    #1;
    chk("bp_rd1_ready", bus.req_ready, 1'b1);
    tick();
    drive(1, 0, 8'h22, 8'h00, 48'h0);
    #1;
    chk("bp_credit_out", {bus.req_ready, sram_en},
        {1'b0, 1'b0});
    chk("bp_head0", {bus.resp_valid, bus.resp_rdata},
        {1'b1, pat(0)});
    tick();
    chk("bp_full_stall", {bus.req_ready, sram_en},
        {1'b0, 1'b0});
    drive(1, 1, 8'h30, 8'hFF, 48'h3030_3030_3030);
    #1;
    chk("full_wr0", {bus.req_ready, sram_en, sram_wmode},
        {1'b1, 1'b1, 1'b1});
    tick();
    drive(1, 1, 8'h31, 8'hFF, 48'h3131_3131_3131);
    #1;
    chk("full_wr1", {bus.req_ready, sram_en, sram_wmode},
        {1'b1, 1'b1, 1'b1});
    tick();
    drive(0, 0, 8'h00, 8'h00, 48'h0);
    #1;
    chk("full_head_kept", {bus.resp_valid, bus.resp_rdata},
        {1'b1, pat(0)});
    bus.resp_ready = 1'b1;
    drive(1, 0, 8'h22, 8'h00, 48'h0);
    #1;
    chk("pop_frees_credit", bus.req_ready, 1'b1);
    tick();
    drive(1, 0, 8'h23, 8'h00, 48'h0);
    #1;
    chk("drain_rd3_ready", bus.req_ready, 1'b1);
    chk("order_1", {bus.resp_valid, bus.resp_rdata},
        {1'b1, pat(1)});
    tick();
    drive(0, 0, 8'h00, 8'h00, 48'h0);
    #1;
    chk("order_2", {bus.resp_valid, bus.resp_rdata},
        {1'b1, pat(2)});
    tick();
    chk("order_3", {bus.resp_valid, bus.resp_rdata},
        {1'b1, pat(3)});
    tick();
    chk("drain_empty", bus.resp_valid, 1'b0);

    // 4: streaming reads, one accept/response per cycle
    s_addr[0] = 8'h20; s_exp[0] = pat(0);
    s_addr[1] = 8'h21; s_exp[1] = pat(1);
    s_addr[2] = 8'h22; s_exp[2] = pat(2);
    s_addr[3] = 8'h23; s_exp[3] = pat(3);
    s_addr[4] = 8'h50; s_exp[4] = 48'h0;
    s_addr[5] = 8'h30; s_exp[5] = 48'h3030_3030_3030;
    s_addr[6] = 8'h31; s_exp[6] = 48'h3131_3131_3131;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) drive(1, 0, s_addr[i], 8'h00, 48'h0);
      else       drive(0, 0, 8'h00, 8'h00, 48'h0);
      #1;
      if (i < 7) chk("stream_ready", bus.req_ready, 1'b1);
      if (i >= 2) begin
        chk("stream_resp", {bus.resp_valid, bus.resp_rdata},
            {1'b1, s_exp[i-2]});
      end
      tick();
    end
    chk("stream_done", bus.resp_valid, 1'b0);

    // 5: reset with a response pending, then again
    // mid-sweep at init_ptr=100
    bus.resp_ready = 1'b0;
    drive(1, 0, 8'h20, 8'h00, 48'h0);
    tick();
    drive(0, 0, 8'h00, 8'h00, 48'h0);
    tick();
    chk("pending_resp", bus.resp_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_reset("async_reset_run");
    tick();
    reset_n = 1'b1;
    #1;
    run_init(100);
    chk("sweep_at_100", {sram_en, sram_addr}, {1'b1, 8'd100});
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_reset("async_reset_init");
    tick();
    reset_n = 1'b1;
    #1;
    run_init(256);
    chk("reinit_done", init_done, 1'b1);
    bus.resp_ready = 1'b1;
    drive(1, 0, 8'h20, 8'h00, 48'h0);
    tick();
    drive(0, 0, 8'h00, 8'h00, 48'h0);
    tick();
    chk("refill_zero", {bus.resp_valid, bus.resp_rdata},
        {1'b1, 48'h0});
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
